fifo_rd_stream: RTL and testbench

Read-side consumer for the team's async FIFO, running entirely in the read clock domain. It drives the FIFO's rinc, captures rdata whenever rempty is low, and presents the words as a valid/ready stream. A 2-entry skid buffer provides the storage, and a beat counter frames every PKT_LEN words as one packet. It sits between the FIFO read port and downstream logic such as a DMA or protocol engine.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/rd_skid_buf.sv | 49 ++++
 rtl/fifo_rd_stream.sv | 63 ++++++
 tb/tb_fifo_rd_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the async FIFO read-side blocks
package fifo_pkg;

    localparam int FIFO_DSIZE = 8;

    typedef logic [1:0] occ_t;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 2-entry FIFO-ordered skid buffer with simultaneous push/pop
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [DSIZE-1:0] head_data
);

    logic [DSIZE-1:0] tail_data;

    // The head register only changes on pop or on a push into an empty
    // buffer, so the presented word stays stable until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_data <= push_data;
                    else             tail_data <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read port to framed valid/ready stream
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE   = FIFO_DSIZE,
    parameter int PKT_LEN = 16,
    parameter int CNTW    = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic             fifo_rempty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [CNTW-1:0]  pkt_cnt,
    output logic             busy
);

    localparam int            BW        = clog2_min1(PKT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    occ_t          occ;
    logic          hs;
    logic [BW-1:0] beat_cnt;

    // Pop decision uses only registered occupancy, never m_ready.
    assign fifo_rinc = en & ~fifo_rempty & (occ != 2'd2) & ~rrst;
    assign m_valid   = (occ != 2'd0);
    assign hs        = m_valid & m_ready;
    assign m_last    = (beat_cnt == LAST_BEAT);
    assign busy      = (occ != 2'd0) | (en & ~fifo_rempty);

    rd_skid_buf #(
        .DSIZE(DSIZE)
    ) u_buf (
        .clk      (rclk),
        .rst      (rrst),
        .push     (fifo_rinc),
        .push_data(fifo_rdata),
        .pop      (hs),
        .occ      (occ),
        .head_data(m_data)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (hs) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + CNTW'(1);
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;

    logic        en_a = 1'b0, m_ready_a = 1'b0;
    logic        rempty_a, rinc_a, m_valid_a, m_last_a, busy_a;
    logic [7:0]  rdata_a, m_data_a;
    logic [15:0] pkt_cnt_a;
    int          rd_ptr_a = 0, lim_a = 0;

    logic        en_b = 1'b0, m_ready_b = 1'b0;
    logic        rempty_b, rinc_b, m_valid_b, m_last_b, busy_b;
    logic [7:0]  rdata_b, m_data_b;
    logic [1:0]  pkt_cnt_b;
    int          rd_ptr_b = 0, lim_b = 0;

    int n_cmp = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } rec_t;
    rec_t got[$];

    typedef struct {
        logic       rdy;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic [1:0] pkt;
    } vec_t;
    vec_t tbl[8];

    always #5 rclk = ~rclk;

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16), .CNTW(16)) dut_a (
        .rclk(rclk), .rrst(rrst), .en(en_a), .fifo_rempty(rempty_a),
        .fifo_rdata(rdata_a), .fifo_rinc(rinc_a), .m_valid(m_valid_a),
        .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a),
        .pkt_cnt(pkt_cnt_a), .busy(busy_a)
    );

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1), .CNTW(2)) dut_b (
        .rclk(rclk), .rrst(rrst), .en(en_b), .fifo_rempty(rempty_b),
        .fifo_rdata(rdata_b), .fifo_rinc(rinc_b), .m_valid(m_valid_b),
        .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
        .pkt_cnt(pkt_cnt_b), .busy(busy_b)
    );

    // FIFO models: word value equals its index, availability bounded by lim.
    assign rempty_a = (rd_ptr_a >= lim_a);
    assign rdata_a  = rd_ptr_a[7:0];
    assign rempty_b = (rd_ptr_b >= lim_b);
    assign rdata_b  = rd_ptr_b[7:0];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rrst) begin
            rd_ptr_a <= 0;
            rd_ptr_b <= 0;
        end else begin
            if (rinc_a) rd_ptr_a <= rd_ptr_a + 1;
            if (rinc_b) rd_ptr_b <= rd_ptr_b + 1;
        end
    end

    // Mid-cycle sample: a word seen valid&ready here is taken at the next edge.
    always @(negedge rclk) begin
        if (!rrst && m_valid_a && m_ready_a) begin
            rec_t r;
            r.data = m_data_a;
            r.last = m_last_a;
            r.cyc  = cyc;
            got.push_back(r);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge rclk);
            #1;
            k++;
        end
        check("wait_got_timeout", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic do_reset(input int la, input logic ea, input logic ra);
        @(posedge rclk);
        #1;
        rrst = 1'b1;
        lim_a = la; en_a = ea; m_ready_a = ra;
        en_b = 1'b0; m_ready_b = 1'b0; lim_b = 0;
        @(posedge rclk);
        #1;
        got.delete();
        @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    initial begin
        int cnt;

        // Test 1: reset with FIFO non-empty, then first pop right after release
        lim_a = 32; en_a = 1'b1; m_ready_a = 1'b1;
        @(posedge rclk);
        @(negedge rclk);
        check("t1_rinc_in_reset", 32'(rinc_a), 32'd0);
        check("t1_valid_in_reset", 32'(m_valid_a), 32'd0);
        check("t1_pkt_in_reset", 32'(pkt_cnt_a), 32'd0);
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        @(negedge rclk);
        check("t1_rinc_first_cycle", 32'(rinc_a), 32'd1);

        // Test 2: 32 words, one per cycle, framed every 16
        wait_got(32, 80);
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            check($sformatf("t2_data_%0d", i), 32'(got[i].data), 32'(i));
            check($sformatf("t2_last_%0d", i), 32'(got[i].last), 32'((i % 16) == 15));
            check($sformatf("t2_gap_%0d", i), 32'(got[i].cyc - got[0].cyc), 32'(i));
        end
        @(negedge rclk);
        check("t2_pkt_cnt", 32'(pkt_cnt_a), 32'd2);

        // Test 3: backpressure after word 4 for 5 cycles
        do_reset(32, 1'b1, 1'b1);
        wait_got(5, 20);
        m_ready_a = 1'b0;
        @(negedge rclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            check("t3_rinc_held", 32'(rinc_a), 32'd0);
            check("t3_data_held", 32'(m_data_a), 32'h05);
            check("t3_occ_full", 32'(dut_a.u_buf.occ), 32'd2);
        end
        @(posedge rclk);
        #1;
        m_ready_a = 1'b1;
        wait_got(10, 20);
        for (int i = 0; i < 10 && i < got.size(); i++)
            check($sformatf("t3_order_%0d", i), 32'(got[i].data), 32'(i));

        // Test 4: FIFO empty after 0x03, refill 10 cycles later
        do_reset(4, 1'b1, 1'b1);
        wait_got(4, 20);
        @(negedge rclk);
        check("t4_valid_drops", 32'(m_valid_a), 32'd0);
        check("t4_last_word", 32'(got[got.size()-1].data), 32'h03);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            if (rinc_a) cnt++;
        end
        check("t4_no_pop_empty", 32'(cnt), 32'd0);
        check("t4_busy_idle", 32'(busy_a), 32'd0);
        @(posedge rclk);
        #1;
        lim_a = 32;
        wait_got(16, 40);
        check("t4_w4_data", 32'(got[4].data), 32'h04);
        check("t4_w4_last", 32'(got[4].last), 32'd0);
        check("t4_w14_last", 32'(got[14].last), 32'd0);
        check("t4_w15_last", 32'(got[15].last), 32'd1);

        // Test 5: en=0 with two words buffered
        do_reset(32, 1'b1, 1'b0);
        repeat (2) @(posedge rclk);
        #1;
        en_a = 1'b0;
        m_ready_a = 1'b1;
        check("t5_popped_two", 32'(rd_ptr_a), 32'd2);
        repeat (6) @(posedge rclk);
        @(negedge rclk);
        check("t5_drained", 32'(got.size()), 32'd2);
        check("t5_no_more_pops", 32'(rd_ptr_a), 32'd2);
        check("t5_valid_low", 32'(m_valid_a), 32'd0);
        check("t5_busy_low", 32'(busy_a), 32'd0);
        @(posedge rclk);
        #1;
        en_a = 1'b1;
        wait_got(6, 20);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check($sformatf("t5_order_%0d", i), 32'(got[i].data), 32'(i));

        // Test 6: PKT_LEN=1, CNTW=2 table with one stall cycle
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 8'h00, 1'b1, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 2'd1};
        tbl[3] = '{1'b1, 1'b1, 8'h01, 1'b1, 2'd1};
        tbl[4] = '{1'b1, 1'b1, 8'h02, 1'b1, 2'd2};
        tbl[5] = '{1'b1, 1'b1, 8'h03, 1'b1, 2'd3};
        tbl[6] = '{1'b1, 1'b1, 8'h04, 1'b1, 2'd0};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        @(posedge rclk);
        #1;
        rrst = 1'b1;
        en_a = 1'b0; m_ready_a = 1'b0;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        lim_b = 5; en_b = 1'b1; m_ready_b = tbl[0].rdy;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            check($sformatf("t6_valid_%0d", i), 32'(m_valid_b), 32'(tbl[i].vld));
            if (tbl[i].vld)
                check($sformatf("t6_data_%0d", i), 32'(m_data_b), 32'(tbl[i].data));
            check($sformatf("t6_last_%0d", i), 32'(m_last_b), 32'(tbl[i].last));
            check($sformatf("t6_pkt_%0d", i), 32'(pkt_cnt_b), 32'(tbl[i].pkt));
            @(posedge rclk);
            #1;
            if (i < 7) m_ready_b = tbl[i+1].rdy;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
